dcache_wt: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache between the CPU memory stage and a variable-latency backing data memory.
- Services the memory-stage load/store request (ALU result address, store data, DataWidth code).
- Hit loads return data in the same cycle; misses and all stores raise `stall`, which the hazard unit uses to freeze the pipeline.

---
 rtl/dcache_wt.sv | 235 +++++++++++++++++++++++
 tb/tb_dcache_wt.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache for the memory stage.
// Define DCACHE_WT_PERF_EN to add the saturating perf_hits / perf_misses counters.
module dcache_wt #(
    parameter int SETS  = 8,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_width,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
`ifdef DCACHE_WT_PERF_EN
    ,
    output logic [31:0] perf_hits,
    output logic [31:0] perf_misses
`endif
);

    localparam int WB = $clog2(WORDS);
    localparam int IB = $clog2(SETS);
    localparam int TB = 32 - 2 - WB - IB;
    localparam int LW = 32 - 2 - WB;

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [WB-1:0]   cnt_q, cnt_d;
    logic [LW-1:0]   line_q, line_d;
    logic [SETS-1:0] valid_q, valid_d;
    logic [TB-1:0]   tag_q  [SETS];
    logic [31:0]     data_q [SETS][WORDS];

    logic [1:0]      req_off;
    logic [WB-1:0]   req_word;
    logic [IB-1:0]   req_idx;
    logic [TB-1:0]   req_tag;
    logic [IB-1:0]   line_idx;
    logic [TB-1:0]   line_tag;
    logic            hit;
    logic            is_b, is_h, is_uns;
    logic [1:0]      off_eff;
    logic [31:0]     cache_word, shifted, load_val;
    logic [3:0]      st_be;
    logic [31:0]     st_wdata;
    logic            fill_we, fill_last, merge_we;

    assign req_off  = req_addr[1:0];
    assign req_word = req_addr[WB+1:2];
    assign req_idx  = req_addr[WB+IB+1:WB+2];
    assign req_tag  = req_addr[31:WB+IB+2];
    assign line_idx = line_q[IB-1:0];
    assign line_tag = line_q[LW-1:IB];

    assign hit        = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign cache_word = data_q[req_idx][req_word];

    // Misaligned half at offset 3 and misaligned words fold down to an aligned lane.
    always_comb begin
        is_b    = (req_width[1:0] == 2'b00);
        is_h    = (req_width[1:0] == 2'b01);
        is_uns  = req_width[2];
        off_eff = 2'b00;
        if (is_b)
            off_eff = req_off;
        else if (is_h)
            off_eff = (req_off == 2'd3) ? 2'd2 : req_off;
    end

    always_comb begin
        shifted = cache_word >> {off_eff, 3'b000};
        if (is_b)
            load_val = is_uns ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        else if (is_h)
            load_val = is_uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        else
            load_val = cache_word;
    end

    always_comb begin
        if (is_b) begin
            st_be    = 4'b0001 << off_eff;
            st_wdata = {4{req_wdata[7:0]}};
        end else if (is_h) begin
            st_be    = 4'b0011 << off_eff;
            st_wdata = (off_eff == 2'd1) ? {8'h0, req_wdata[15:0], 8'h0} : {2{req_wdata[15:0]}};
        end else begin
            st_be    = 4'b1111;
            st_wdata = req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_we)
                        state_d = S_WRITE;
                    else if (!hit)
                        state_d = S_REFILL;
                end
            end
            S_REFILL: if (mem_ack && cnt_q == WB'(WORDS - 1)) state_d = S_RESP;
            S_WRITE:  if (mem_ack) state_d = S_RESP;
            default:  state_d = S_IDLE;
        endcase
    end

    assign fill_we   = (state_q == S_REFILL) && mem_ack;
    assign fill_last = fill_we && (cnt_q == WB'(WORDS - 1));
    assign merge_we  = (state_q == S_WRITE) && mem_ack && hit;

    // The target line is invalidated as the refill starts so an aborted refill never looks valid.
    always_comb begin
        cnt_d   = cnt_q;
        line_d  = line_q;
        valid_d = valid_q;
        if (state_q == S_IDLE && req_valid && !req_we && !hit) begin
            cnt_d            = '0;
            line_d           = req_addr[31:WB+2];
            valid_d[req_idx] = 1'b0;
        end
        if (fill_we)
            cnt_d = cnt_q + WB'(1);
        if (fill_last)
            valid_d[line_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (fill_we)
            data_q[line_idx][cnt_q] <= mem_rdata;
        if (fill_last)
            tag_q[line_idx] <= line_tag;
        if (merge_we) begin
            for (int i = 0; i < 4; i++)
                if (st_be[i])
                    data_q[req_idx][req_word][8*i +: 8] <= st_wdata[8*i +: 8];
        end
    end

    always_comb begin
        rdata     = '0;
        stall     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (rst) begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        if (req_we || !hit)
                            stall = 1'b1;
                        else
                            rdata = load_val;
                    end
                end
                S_REFILL: begin
                    stall    = 1'b1;
                    mem_req  = 1'b1;
                    mem_be   = 4'b1111;
                    mem_addr = {line_q, cnt_q, 2'b00};
                end
                S_WRITE: begin
                    stall     = 1'b1;
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = {req_addr[31:2], 2'b00};
                    mem_be    = st_be;
                    mem_wdata = st_wdata;
                end
                default: begin
                    if (!req_we)
                        rdata = load_val;
                end
            endcase
        end
    end

`ifdef DCACHE_WT_PERF_EN
    logic [31:0] perf_hits_q, perf_hits_d;
    logic [31:0] perf_misses_q, perf_misses_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_hits_q   <= '0;
            perf_misses_q <= '0;
        end else begin
            perf_hits_q   <= perf_hits_d;
            perf_misses_q <= perf_misses_d;
        end
    end

    always_comb begin
        perf_hits_d   = perf_hits_q;
        perf_misses_d = perf_misses_q;
        if (state_q == S_IDLE && req_valid && !req_we) begin
            if (hit && perf_hits_q != 32'hFFFF_FFFF)
                perf_hits_d = perf_hits_q + 32'd1;
            if (!hit && perf_misses_q != 32'hFFFF_FFFF)
                perf_misses_d = perf_misses_q + 32'd1;
        end
    end

    assign perf_hits   = perf_hits_q;
    assign perf_misses = perf_misses_q;
`endif

endmodule

// File: tb/tb_dcache_wt.sv
// Bench for dcache_wt: directed scenarios then random loads/stores against a
// behavioural memory + tag model.
module tb_dcache_wt;
    localparam int SETS  = 8;
    localparam int WORDS = 4;
    localparam int LINE  = 4 * WORDS;

    logic        clk, rst;
    logic        req_valid, req_we;
    logic [2:0]  req_width;
    logic [31:0] req_addr, req_wdata;
    logic [31:0] rdata;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;
`ifdef DCACHE_WT_PERF_EN
    logic [31:0] perf_hits, perf_misses;
`endif

    dcache_wt #(.SETS(SETS), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_width(req_width),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rdata(rdata), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef DCACHE_WT_PERF_EN
        , .perf_hits(perf_hits), .perf_misses(perf_misses)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int hits_m = 0;
    int misses_m = 0;

    logic [31:0] mem [int unsigned];
    bit          mvalid [SETS];
    int unsigned mtag   [SETS];

    function automatic logic [31:0] mget(input logic [31:0] a);
        int unsigned k;
        k = a >> 2;
        if (mem.exists(k)) return mem[k];
        return k * 32'h9E37_79B1 + 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] wd, input logic [2:0] w, input int off);
        logic [31:0] s;
        s = wd >> (8 * off);
        case (w)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b100:  return {24'h0, s[7:0]};
            3'b101:  return {16'h0, s[15:0]};
            default: return wd;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic access(input bit we, input logic [2:0] w, input logic [31:0] a,
                          input logic [31:0] wd, input int lat, output logic [31:0] rd_obs);
        int unsigned idx, tg, off, n;
        bit          exp_hit;
        logic [31:0] line, xaddr, exp_wd, mask, cur;
        logic [3:0]  exp_be;
        idx  = (a / LINE) % SETS;
        tg   = a / (LINE * SETS);
        off  = a % 4;
        line = a & ~(LINE - 1);
        case (w[1:0])
            2'b00:   begin exp_be = 4'b0001 << off; exp_wd = {4{wd[7:0]}};  end
            2'b01:   begin exp_be = 4'b0011 << off; exp_wd = {2{wd[15:0]}}; end
            default: begin exp_be = 4'b1111;        exp_wd = wd;            end
        endcase
        mask = {{8{exp_be[3]}}, {8{exp_be[2]}}, {8{exp_be[1]}}, {8{exp_be[0]}}};
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_width = w; req_addr = a; req_wdata = wd;
        #1;
        exp_hit = !we && mvalid[idx] && (mtag[idx] == tg);
        check("issue_stall", stall, !exp_hit);
        rd_obs = rdata;
        if (exp_hit) begin
            hits_m++;
            check("hit_mem_req", mem_req, 0);
            check("hit_rdata", rdata, exp_load(mget(a), w, off));
        end else begin
            if (!we) misses_m++;
            n = we ? 1 : WORDS;
            for (int k = 0; k < n; k++) begin
                xaddr = we ? (a & ~32'd3) : line + 4 * k;
                for (int c = 1; c <= lat; c++) begin
                    @(negedge clk);
                    mem_ack = 1'b0;
                    #1;
                    check("busy_mem_req", mem_req, 1);
                    check("busy_stall", stall, 1);
                    check("mem_we", mem_we, we);
                    check("mem_addr", mem_addr, xaddr);
                    if (we) begin
                        check("mem_be", mem_be, exp_be);
                        check("mem_wdata", mem_wdata & mask, exp_wd & mask);
                    end else begin
                        check("refill_be", mem_be, 4'b1111);
                    end
                    if (c == lat) begin
                        mem_ack   = 1'b1;
                        mem_rdata = we ? $urandom : mget(xaddr);
                    end
                end
            end
            @(negedge clk);
            mem_ack = 1'b0;
            #1;
            check("resp_stall", stall, 0);
            check("resp_mem_req", mem_req, 0);
            rd_obs = rdata;
            if (!we) begin
                check("resp_rdata", rdata, exp_load(mget(a), w, off));
                mvalid[idx] = 1'b1;
                mtag[idx]   = tg;
            end else begin
                cur = mget(a);
                mem[a >> 2] = (cur & ~mask) | (exp_wd & mask);
            end
        end
        req_valid = 1'b0;
    endtask

    logic [31:0] rd;
    logic [2:0]  wsel [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_width = 3'b010;
        req_addr = '0; req_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        for (int i = 0; i < SETS; i++) begin mvalid[i] = 1'b0; mtag[i] = 0; end
        mem[32'h100 >> 2] = 32'hDEAD_BEEF;
        #1;
        check("rst_stall", stall, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rdata", rdata, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Cold miss, then hits and sub-word loads on the same line
        access(0, 3'b010, 32'h100, 0, 2, rd);
        check("cold_word", rd, 32'hDEAD_BEEF);
        access(0, 3'b010, 32'h100, 0, 1, rd);
        check("hit_word", rd, 32'hDEAD_BEEF);
        access(0, 3'b000, 32'h101, 0, 1, rd);
        check("lb_101", rd, 32'hFFFF_FFBE);
        access(0, 3'b100, 32'h101, 0, 1, rd);
        check("lbu_101", rd, 32'h0000_00BE);

        // Store half hit merges into the cached line
        access(1, 3'b001, 32'h102, 32'h0000_1234, 2, rd);
        access(0, 3'b010, 32'h100, 0, 1, rd);
        check("merged_word", rd, 32'h1234_BEEF);

        // Store miss does not allocate; conflict misses on one index
        access(1, 3'b010, 32'h400, 32'hCAFE_F00D, 1, rd);
        access(0, 3'b010, 32'h400, 0, 3, rd);
        check("store_miss_data", rd, 32'hCAFE_F00D);
        access(0, 3'b010, 32'h100, 0, 1, rd);
        access(0, 3'b010, 32'h100 + LINE * SETS, 0, 1, rd);
        access(0, 3'b010, 32'h100, 0, 2, rd);
        check("conflict_reload", rd, 32'h1234_BEEF);

        for (int t = 0; t < 200; t++) begin
            bit          we;
            logic [2:0]  w;
            logic [31:0] a;
            we = ($urandom_range(0, 2) == 0);
            w  = we ? wsel[$urandom_range(0, 2)] : wsel[$urandom_range(0, 4)];
            a  = $urandom_range(0, 255) * 4;
            if (w[1:0] == 2'b00) a = a + $urandom_range(0, 3);
            else if (w[1:0] == 2'b01) a = a + 2 * $urandom_range(0, 1);
            access(we, w, a, $urandom, $urandom_range(1, 3), rd);
        end

`ifdef DCACHE_WT_PERF_EN
        check("perf_hits", perf_hits, hits_m);
        check("perf_misses", perf_misses, misses_m);
`endif

        // Reset in the middle of a refill, after the second word is acked
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_width = 3'b010; req_addr = 32'h1300;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            #1;
            check("abort_addr", mem_addr, 32'h1300 + 4 * k);
            mem_ack   = 1'b1;
            mem_rdata = mget(32'h1300 + 4 * k);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        rst     = 1'b0;
        #1;
        check("abort_stall", stall, 0);
        check("abort_mem_req", mem_req, 0);
`ifdef DCACHE_WT_PERF_EN
        check("perf_hits_rst", perf_hits, 0);
        check("perf_misses_rst", perf_misses, 0);
`endif
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b0;
        for (int i = 0; i < SETS; i++) mvalid[i] = 1'b0;
        hits_m = 0;
        misses_m = 0;
        access(0, 3'b010, 32'h100, 0, 1, rd);
        check("post_rst_word", rd, 32'h1234_BEEF);
        access(0, 3'b010, 32'h1300, 0, 1, rd);
        access(0, 3'b010, 32'h100, 0, 1, rd);
`ifdef DCACHE_WT_PERF_EN
        check("perf_hits_end", perf_hits, hits_m);
        check("perf_misses_end", perf_misses, misses_m);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
